// File: rtl/regfile_writeback.sv
// Register-file write-port arbiter: merges ALU and load results into one write per cycle.
// Loads that lose to the ALU wait in a small FIFO that is forced through after STARVE_LIM blocked cycles.
module regfile_writeback #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int LQ_DEPTH   = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                          clk,
    input  logic                          rst_n_i,
    input  logic                          alu_valid_i,
    output logic                          alu_ready_o,
    input  logic [ADDR_W-1:0]             alu_rd_i,
    input  logic [DATA_W-1:0]             alu_data_i,
    input  logic                          lsu_valid_i,
    output logic                          lsu_ready_o,
    input  logic [ADDR_W-1:0]             lsu_rd_i,
    input  logic [DATA_W-1:0]             lsu_data_i,
    output logic                          rf_wen_o,
    output logic [ADDR_W-1:0]             rf_waddr_o,
    output logic [DATA_W-1:0]             rf_wdata_o,
    output logic [2**ADDR_W-1:0]          pend_mask_o,
    output logic [$clog2(LQ_DEPTH):0]     lq_count_o
);
    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIM + 1);
    localparam int NREG  = 2**ADDR_W;

    logic [ADDR_W-1:0] rd_q   [LQ_DEPTH];
    logic [DATA_W-1:0] data_q [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] valid_reg;
    logic [PTR_W-1:0]  head_reg, tail_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [STV_W-1:0]  starve_reg, starve_next;
    logic              wen_reg, wen_next;
    logic [ADDR_W-1:0] waddr_reg, waddr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              q_empty, force_pop, lsu_wr, push, pop, bypass;
    logic [NREG-1:0]   entry_mask [LQ_DEPTH];

    assign q_empty     = (count_reg == '0);
    assign force_pop   = (starve_reg == STV_W'(STARVE_LIM)) && !q_empty;
    assign alu_ready_o = !force_pop;
    assign lsu_ready_o = (count_reg < CNT_W'(LQ_DEPTH));
    assign lsu_wr      = lsu_valid_i && lsu_ready_o && (lsu_rd_i != '0);
    assign push        = lsu_wr && !bypass;

    always_comb begin
        pop         = 1'b0;
        bypass      = 1'b0;
        wen_next    = 1'b0;
        waddr_next  = '0;
        wdata_next  = '0;
        starve_next = starve_reg;
        if (force_pop) begin
            pop         = 1'b1;
            wen_next    = 1'b1;
            waddr_next  = rd_q[head_reg];
            wdata_next  = data_q[head_reg];
            starve_next = '0;
        end else if (alu_valid_i && alu_rd_i != '0) begin
            wen_next   = 1'b1;
            waddr_next = alu_rd_i;
            wdata_next = alu_data_i;
            if (!q_empty && starve_reg != STV_W'(STARVE_LIM))
                starve_next = starve_reg + STV_W'(1);
        end else if (!q_empty) begin
            pop         = 1'b1;
            wen_next    = 1'b1;
            waddr_next  = rd_q[head_reg];
            wdata_next  = data_q[head_reg];
            starve_next = '0;
        end else if (lsu_wr) begin
            bypass     = 1'b1;
            wen_next   = 1'b1;
            waddr_next = lsu_rd_i;
            wdata_next = lsu_data_i;
        end
        if (q_empty)
            starve_next = '0;
    end

    // Payload storage needs no reset; valid_reg alone marks live entries.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail_reg]   <= lsu_rd_i;
            data_q[tail_reg] <= lsu_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            valid_reg  <= '0;
            head_reg   <= '0;
            tail_reg   <= '0;
            count_reg  <= '0;
            starve_reg <= '0;
            wen_reg    <= 1'b0;
            waddr_reg  <= '0;
            wdata_reg  <= '0;
        end else begin
            if (push) begin
                valid_reg[tail_reg] <= 1'b1;
                tail_reg            <= tail_reg + PTR_W'(1);
            end
            if (pop) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            starve_reg <= starve_next;
            wen_reg    <= wen_next;
            waddr_reg  <= waddr_next;
            wdata_reg  <= wdata_next;
        end
    end

    for (genvar gi = 0; gi < LQ_DEPTH; gi++) begin : g_mask
        assign entry_mask[gi] = valid_reg[gi] ? (NREG'(1) << rd_q[gi]) : '0;
    end

    always_comb begin
        pend_mask_o = '0;
        for (int i = 0; i < LQ_DEPTH; i++)
            pend_mask_o = pend_mask_o | entry_mask[i];
        pend_mask_o[0] = 1'b0;
    end

    assign rf_wen_o   = wen_reg;
    assign rf_waddr_o = waddr_reg;
    assign rf_wdata_o = wdata_reg;
    assign lq_count_o = count_reg;
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: hand-computed expectations checked with immediate assertions.
module tb_regfile_writeback;
    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        alu_valid_i, alu_ready_o;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        lsu_valid_i, lsu_ready_o;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_data_i;
    logic        rf_wen_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [31:0] pend_mask_o;
    logic [1:0]  lq_count_o;

    int vectors = 0;
    int miscompares = 0;

    regfile_writeback #(.DATA_W(32), .ADDR_W(5), .LQ_DEPTH(2), .STARVE_LIM(4)) dut (
        .clk(clk), .rst_n_i(rst_n_i),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
        .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
        .rf_wen_o(rf_wen_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .pend_mask_o(pend_mask_o), .lq_count_o(lq_count_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rf_wen_o) $display("write x%0d = %h", rf_waddr_o, rf_wdata_o);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid_i = v; alu_rd_i = rd; alu_data_i = d;
    endtask

    task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lsu_valid_i = v; lsu_rd_i = rd; lsu_data_i = d;
    endtask

    task automatic exp_wr(input string tag, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, "_wen"}, 64'(rf_wen_o), 64'd1);
        chk({tag, "_waddr"}, 64'(rf_waddr_o), 64'(rd));
        chk({tag, "_wdata"}, 64'(rf_wdata_o), 64'(d));
    endtask

    initial begin
        rst_n_i = 1'b0;
        set_alu(0, 0, 0);
        set_lsu(0, 0, 0);
        tick(); tick();
        rst_n_i = 1'b1;
        chk("rst_wen", 64'(rf_wen_o), 64'd0);
        chk("rst_lsu_ready", 64'(lsu_ready_o), 64'd1);
        chk("rst_alu_ready", 64'(alu_ready_o), 64'd1);
        chk("rst_pend", 64'(pend_mask_o), 64'd0);
        chk("rst_count", 64'(lq_count_o), 64'd0);

        // ALU only
        set_alu(1, 5, 32'hDEADBEEF);
        tick();
        exp_wr("alu_only", 5, 32'hDEADBEEF);
        set_alu(0, 0, 0);
        tick();
        chk("alu_only_idle", 64'(rf_wen_o), 64'd0);

        // Collision: ALU wins, load queued
        set_alu(1, 3, 32'h11);
        set_lsu(1, 7, 32'h22);
        tick();
        exp_wr("coll_alu", 3, 32'h11);
        chk("coll_count1", 64'(lq_count_o), 64'd1);
        chk("coll_pend", 64'(pend_mask_o), 64'h80);
        set_alu(0, 0, 0);
        set_lsu(0, 0, 0);
        tick();
        exp_wr("coll_lsu", 7, 32'h22);
        chk("coll_count0", 64'(lq_count_o), 64'd0);
        chk("coll_pend0", 64'(pend_mask_o), 64'd0);
        tick();
        chk("coll_idle", 64'(rf_wen_o), 64'd0);

        // LSU alone on empty queue bypasses
        set_lsu(1, 12, 32'hC0C);
        tick();
        set_lsu(0, 0, 0);
        exp_wr("bypass", 12, 32'hC0C);
        chk("bypass_count", 64'(lq_count_o), 64'd0);
        chk("bypass_pend", 64'(pend_mask_o), 64'd0);
        tick();

        // Full queue and starvation force
        set_alu(1, 1, 32'h101);
        set_lsu(1, 8, 32'h808);
        tick();
        exp_wr("full_a1", 1, 32'h101);
        chk("full_count1", 64'(lq_count_o), 64'd1);
        chk("full_lsu_ready1", 64'(lsu_ready_o), 64'd1);
        set_alu(1, 2, 32'h102);
        set_lsu(1, 9, 32'h909);
        tick();
        exp_wr("full_a2", 2, 32'h102);
        chk("full_count2", 64'(lq_count_o), 64'd2);
        chk("full_lsu_ready0", 64'(lsu_ready_o), 64'd0);
        chk("full_pend", 64'(pend_mask_o), 64'h300);
        set_lsu(0, 0, 0);
        set_alu(1, 3, 32'h103);
        chk("full_alu_ready3", 64'(alu_ready_o), 64'd1);
        tick();
        exp_wr("full_a3", 3, 32'h103);
        set_alu(1, 4, 32'h104);
        tick();
        exp_wr("full_a4", 4, 32'h104);
        set_alu(1, 5, 32'h105);
        chk("full_alu_ready5", 64'(alu_ready_o), 64'd1);
        tick();
        exp_wr("full_a5", 5, 32'h105);
        set_alu(1, 6, 32'h106);
        chk("force_alu_ready", 64'(alu_ready_o), 64'd0);
        tick();
        exp_wr("force_l8", 8, 32'h808);
        chk("force_count", 64'(lq_count_o), 64'd1);
        chk("force_pend", 64'(pend_mask_o), 64'h200);
        chk("after_force_ready", 64'(alu_ready_o), 64'd1);
        tick();
        exp_wr("held_a6", 6, 32'h106);
        set_alu(0, 0, 0);
        tick();
        exp_wr("drain_l9", 9, 32'h909);
        chk("drain_count", 64'(lq_count_o), 64'd0);
        tick();
        chk("drain_idle", 64'(rf_wen_o), 64'd0);

        // x0 writes
        set_alu(1, 0, 32'hAAAA);
        set_lsu(1, 0, 32'hBBBB);
        chk("x0_alu_ready", 64'(alu_ready_o), 64'd1);
        chk("x0_lsu_ready", 64'(lsu_ready_o), 64'd1);
        tick();
        chk("x0_wen", 64'(rf_wen_o), 64'd0);
        chk("x0_count", 64'(lq_count_o), 64'd0);
        chk("x0_pend", 64'(pend_mask_o), 64'd0);
        set_alu(1, 4, 32'h44);
        set_lsu(1, 10, 32'hAA);
        tick();
        exp_wr("x0q_alu", 4, 32'h44);
        chk("x0q_count", 64'(lq_count_o), 64'd1);
        set_alu(1, 0, 32'h55);
        set_lsu(0, 0, 0);
        tick();
        exp_wr("x0q_drain", 10, 32'hAA);
        chk("x0q_count0", 64'(lq_count_o), 64'd0);
        set_alu(0, 0, 0);
        tick();
        chk("x0q_idle", 64'(rf_wen_o), 64'd0);

        // Reset with two queued loads
        set_alu(1, 1, 32'h1);
        set_lsu(1, 13, 32'hD);
        tick();
        set_alu(1, 2, 32'h2);
        set_lsu(1, 14, 32'hE);
        tick();
        chk("mid_count2", 64'(lq_count_o), 64'd2);
        set_alu(0, 0, 0);
        set_lsu(0, 0, 0);
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        chk("mrst_wen", 64'(rf_wen_o), 64'd0);
        chk("mrst_count", 64'(lq_count_o), 64'd0);
        chk("mrst_pend", 64'(pend_mask_o), 64'd0);
        chk("mrst_lsu_ready", 64'(lsu_ready_o), 64'd1);
        tick();
        chk("mrst_wen1", 64'(rf_wen_o), 64'd0);
        tick();
        chk("mrst_wen2", 64'(rf_wen_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
